palette_arbiter: RTL and testbench
==================================

PALETTE_ARBITER -- requirements
Module: palette_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4: number of requesters; legal range 2..4.
REQ-002 The block SHALL have parameter MAX_BURST, default 4: maximum consecutive grants to one locked requester; legal range 1..15.
REQ-003 The block SHALL have parameter TRANSP_IDX, default 0: palette index treated as transparent.
REQ-004 The block SHALL have port Clk, input, 1: the single clock; all state SHALL be on its rising edge.
REQ-005 The block SHALL have port Reset, input, 1: asynchronous, active-high reset.
REQ-006 The block SHALL have port req, input, NUM_REQ: per-requester lookup request, level.
REQ-007 The block SHALL have port lock, input, NUM_REQ: per-requester burst hold; meaningful only with req.
REQ-008 The block SHALL have port req_index, input, 4*NUM_REQ: palette index of requester i on bits [4i+3:4i].
REQ-009 The block SHALL have port gnt, output, NUM_REQ: one-hot grant, combinational from req and state.
REQ-010 The block SHALL have port pal_index, output, 4: index driven to the shared 16-entry palette.
REQ-011 The block SHALL have ports pal_red, pal_green and pal_blue, input, 4 each: combinational palette result for pal_index.
REQ-012 The block SHALL have port rsp_valid, output, 1: response strobe.
REQ-013 The block SHALL have port rsp_id, output, 2: requester number of the response.
REQ-014 The block SHALL have port rsp_rgb, output, 12: registered color as {red, green, blue}.
REQ-015 The block SHALL have port rsp_transp, output, 1: the granted index equalled TRANSP_IDX.

Function
REQ-016 The block SHALL assert at most one gnt bit per cycle, and SHALL assert it only for a requester with req high.
REQ-017 If any req bit is high, exactly one gnt bit SHALL be high in the same cycle, so that no cycle with a pending request is idle.
REQ-018 Arbitration SHALL be round-robin: the search SHALL start at (last_id+1) mod NUM_REQ and wrap; last_id SHALL reset to NUM_REQ-1, giving requester 0 first priority after reset.
REQ-019 pal_index SHALL equal req_index of the granted requester, and SHALL be 0 when no grant is given.
REQ-020 Lookup latency SHALL be one cycle: on the edge after a grant, rsp_valid=1, rsp_id=granted id, rsp_rgb={pal_red,pal_green,pal_blue} sampled at that edge, and rsp_transp=(pal_index==TRANSP_IDX).
REQ-021 On the edge after a cycle with no grant, rsp_valid SHALL be 0, and rsp_id, rsp_rgb and rsp_transp SHALL hold their previous values.
REQ-022 The burst counter burst_cnt SHALL be 4 bits; in a cycle with a grant it SHALL load 1 on a change of granted id and increment on a repeated grant to the same id; it SHALL hold its value in a cycle with no grant.
REQ-023 Lock rule: if last_id has req and lock high, and burst_cnt<MAX_BURST, then last_id SHALL be granted again regardless of round-robin order.
REQ-024 When burst_cnt==MAX_BURST, lock SHALL be ignored for that cycle and normal round-robin SHALL apply.
REQ-025 If the locked requester is the only one requesting when burst_cnt==MAX_BURST, it SHALL still be granted and burst_cnt SHALL load 1.
REQ-026 A deassertion of req by the holder SHALL immediately end its burst; no grant SHALL be given to a requester with req low.
REQ-027 Starvation bound: a requester holding req high SHALL be granted within (NUM_REQ-1)*MAX_BURST+1 cycles.
REQ-028 Simultaneous events: a change in req or lock takes effect combinationally in the same cycle; the registered state (last_id, burst_cnt) SHALL update only at the edge.
REQ-029 There SHALL be no handshake beyond req/gnt: a requester that sees gnt high SHALL treat its lookup as accepted at that edge.

Reset
REQ-030 While Reset is high, gnt SHALL be 0, pal_index SHALL be 0, rsp_valid SHALL be 0, rsp_id SHALL be 0, rsp_rgb SHALL be 12'h000, rsp_transp SHALL be 0, last_id SHALL be NUM_REQ-1 and burst_cnt SHALL be 0.
REQ-031 An assertion of Reset in the middle of a burst or lookup SHALL clear all state asynchronously, and no rsp_valid SHALL be issued for the interrupted grant.
REQ-032 On the first edge after Reset deasserts, the block SHALL arbitrate normally.

Verification
REQ-033 The bench SHALL cover: req=4'b1111, lock=0, held 8 cycles -> gnt sequence 0,1,2,3,0,1,2,3; each rsp_id follows one cycle later.
REQ-034 The bench SHALL cover: req_index for requester 2 =4'h4 with a palette model returning B,5,3 -> rsp_rgb=12'hB53, rsp_transp=0, rsp_id=2, one cycle after gnt[2].
REQ-035 The bench SHALL cover: req=4'b0011, lock[0]=1, MAX_BURST=4 -> gnt0 for 4 cycles, then gnt1 for 1 cycle, then gnt0 again.
REQ-036 The bench SHALL cover: a lone requester 3 with lock held 10 cycles -> gnt[3] every cycle, with burst_cnt wrapping 4 to 1.
REQ-037 The bench SHALL cover: Reset pulsed mid-burst -> all outputs zero immediately, and the next grant goes to requester 0 when req[0] is high.
REQ-038 The bench SHALL cover: req_index=TRANSP_IDX (0) with a palette model returning 2,2,2 -> rsp_transp=1 and rsp_rgb=12'h222.

Source files
------------

// File: rtl/palette_arbiter.sv
// Round-robin arbiter with burst lock in front of a shared 16-entry palette.
// The grant and the palette index are combinational; the colour response is registered one cycle later.
module palette_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4,
  parameter int TRANSP_IDX = 0
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   lock,
  input  logic [4*NUM_REQ-1:0] req_index,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [3:0]           pal_index,
  input  logic [3:0]           pal_red,
  input  logic [3:0]           pal_green,
  input  logic [3:0]           pal_blue,
  output logic                 rsp_valid,
  output logic [1:0]           rsp_id,
  output logic [11:0]          rsp_rgb,
  output logic                 rsp_transp
);

  logic [1:0]         last_id_r;
  logic [3:0]         burst_cnt_r;
  logic               any_s;
  logic               hold_s;
  logic               found_s;
  logic [2:0]         sum_s;
  logic [2:0]         cand_s;
  logic [1:0]         gnt_id_s;
  logic [NUM_REQ-1:0] gnt_s;
  logic [3:0]         pal_index_s;
  logic [3:0]         burst_nxt_s;

  // Winner selection: a locked holder under its burst limit keeps the grant, otherwise round-robin from last_id+1.
  always_comb begin
    any_s       = (|req) && !Reset;
    hold_s      = req[last_id_r] && lock[last_id_r] && (burst_cnt_r < 4'(MAX_BURST));
    gnt_id_s    = last_id_r;
    found_s     = 1'b0;
    sum_s       = 3'd0;
    cand_s      = 3'd0;
    gnt_s       = '0;
    pal_index_s = 4'd0;
    if (hold_s) begin
      found_s = 1'b1;
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        sum_s  = {1'b0, last_id_r} + 3'(k);
        cand_s = (sum_s >= 3'(NUM_REQ)) ? (sum_s - 3'(NUM_REQ)) : sum_s;
        if (!found_s && req[cand_s[1:0]]) begin
          gnt_id_s = cand_s[1:0];
          found_s  = 1'b1;
        end else begin
          found_s  = found_s;
        end
      end
    end
    if (any_s) begin
      gnt_s[gnt_id_s] = 1'b1;
      pal_index_s     = req_index[{gnt_id_s, 2'b00} +: 4];
    end else begin
      gnt_s       = '0;
      pal_index_s = 4'd0;
    end
    // Reaching the limit restarts the count, so a lone locked holder cycles 1..MAX_BURST.
    burst_nxt_s = ((gnt_id_s != last_id_r) || (burst_cnt_r >= 4'(MAX_BURST))) ?
                  4'd1 : (burst_cnt_r + 4'd1);
  end

  assign gnt       = gnt_s;
  assign pal_index = pal_index_s;

  // Arbitration state and the one-cycle palette response; outputs hold on idle cycles.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      last_id_r   <= 2'(NUM_REQ - 1);
      burst_cnt_r <= 4'd0;
      rsp_valid   <= 1'b0;
      rsp_id      <= 2'd0;
      rsp_rgb     <= 12'h000;
      rsp_transp  <= 1'b0;
    end else if (any_s) begin
      last_id_r   <= gnt_id_s;
      burst_cnt_r <= burst_nxt_s;
      rsp_valid   <= 1'b1;
      rsp_id      <= gnt_id_s;
      rsp_rgb     <= {pal_red, pal_green, pal_blue};
      rsp_transp  <= (pal_index_s == 4'(TRANSP_IDX));
    end else begin
      rsp_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_palette_arbiter.sv
// Directed bench for palette_arbiter: grants checked per cycle, responses checked by a scoreboard monitor.
module tb_palette_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [15:0] req_index;
  logic [3:0]  gnt;
  logic [3:0]  pal_index;
  logic [3:0]  pal_red, pal_green, pal_blue;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [11:0] rsp_rgb;
  logic        rsp_transp;

  logic [11:0] pal_mem [16];
  logic [14:0] sb [$];
  logic [14:0] last_exp;
  int          n_checks = 0;
  int          n_fail   = 0;

  palette_arbiter #(.NUM_REQ(4), .MAX_BURST(4), .TRANSP_IDX(0)) dut (
    .Clk(Clk), .Reset(Reset), .req(req), .lock(lock), .req_index(req_index),
    .gnt(gnt), .pal_index(pal_index),
    .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rgb(rsp_rgb), .rsp_transp(rsp_transp)
  );

  always #5 Clk = ~Clk;

  assign {pal_red, pal_green, pal_blue} = pal_mem[pal_index];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One arbitration cycle: drive at negedge, check grant/index, queue the expected response.
  task automatic cycle(input logic [3:0] r, input logic [3:0] l, input logic [3:0] eg, input int ecnt);
    logic [1:0] id;
    logic [3:0] idx;
    @(negedge Clk);
    req  = r;
    lock = l;
    #1;
    check("gnt", 32'(gnt), 32'(eg));
    id = 2'd0;
    for (int i = 0; i < 4; i++) if (eg[i]) id = 2'(i);
    idx = (eg == 4'd0) ? 4'd0 : req_index[{id, 2'b00} +: 4];
    check("pal_index", 32'(pal_index), 32'(idx));
    if (ecnt >= 0) check("burst_cnt", 32'(dut.burst_cnt_r), 32'(ecnt));
    if (eg != 4'd0) sb.push_back({id, pal_mem[idx], idx == 4'd0});
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_gnt"}, 32'(gnt), 32'd0);
    check({nm, "_pal_index"}, 32'(pal_index), 32'd0);
    check({nm, "_rsp"}, 32'({rsp_valid, rsp_id, rsp_rgb, rsp_transp}), 32'd0);
    check({nm, "_last_id"}, 32'(dut.last_id_r), 32'd3);
    check({nm, "_burst_cnt"}, 32'(dut.burst_cnt_r), 32'd0);
  endtask

  // Response monitor: pops on rsp_valid, otherwise the response fields must hold.
  always @(posedge Clk) begin
    logic [14:0] e;
    #1;
    if (Reset) begin
      last_exp = 15'd0;
    end else if (rsp_valid) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("rsp", 32'({rsp_id, rsp_rgb, rsp_transp}), 32'(e));
        last_exp = e;
      end
    end else begin
      check("rsp_hold", 32'({rsp_id, rsp_rgb, rsp_transp}), 32'(last_exp));
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) pal_mem[i] = {4'(i), 4'(15 - i), 4'(i ^ 5)};
    pal_mem[4] = 12'hB53;
    pal_mem[0] = 12'h222;
    last_exp   = 15'd0;
    Reset      = 1'b1;
    req        = 4'd0;
    lock       = 4'd0;
    req_index  = {4'h7, 4'h4, 4'h9, 4'h1};
    #1;
    check_all_zero("reset");
    @(negedge Clk);
    Reset = 1'b0;

    // Plain round-robin from requester 0.
    cycle(4'b1111, 4'b0000, 4'b0001, -1);
    cycle(4'b1111, 4'b0000, 4'b0010, -1);
    cycle(4'b1111, 4'b0000, 4'b0100, -1);
    cycle(4'b1111, 4'b0000, 4'b1000, -1);
    cycle(4'b1111, 4'b0000, 4'b0001, -1);
    cycle(4'b1111, 4'b0000, 4'b0010, -1);
    cycle(4'b1111, 4'b0000, 4'b0100, -1);
    cycle(4'b1111, 4'b0000, 4'b1000, -1);

    // Requester 0 locked: four grants, one to requester 1, then back to 0.
    cycle(4'b0011, 4'b0001, 4'b0001, 1);
    cycle(4'b0011, 4'b0001, 4'b0001, 1);
    cycle(4'b0011, 4'b0001, 4'b0001, 2);
    cycle(4'b0011, 4'b0001, 4'b0001, 3);
    cycle(4'b0011, 4'b0001, 4'b0010, 4);
    cycle(4'b0011, 4'b0001, 4'b0001, 1);

    // Lone locked requester 3: granted every cycle, counter wraps 4 -> 1.
    cycle(4'b1000, 4'b1000, 4'b1000, 1);
    cycle(4'b1000, 4'b1000, 4'b1000, 1);
    cycle(4'b1000, 4'b1000, 4'b1000, 2);
    cycle(4'b1000, 4'b1000, 4'b1000, 3);
    cycle(4'b1000, 4'b1000, 4'b1000, 4);
    cycle(4'b1000, 4'b1000, 4'b1000, 1);
    cycle(4'b1000, 4'b1000, 4'b1000, 2);
    cycle(4'b1000, 4'b1000, 4'b1000, 3);
    cycle(4'b1000, 4'b1000, 4'b1000, 4);
    cycle(4'b1000, 4'b1000, 4'b1000, 1);

    // Requester 2 looks up index 4 (B,5,3), then requester 0 the transparent index (2,2,2).
    cycle(4'b0100, 4'b0000, 4'b0100, 2);
    req_index[3:0] = 4'h0;
    cycle(4'b0001, 4'b0000, 4'b0001, 1);
    cycle(4'b0000, 4'b0000, 4'b0000, 1);
    cycle(4'b0000, 4'b0000, 4'b0000, 1);

    // Reset in the middle of a burst: everything clears at once, no response for the dropped grant.
    req_index[3:0] = 4'h1;
    cycle(4'b0011, 4'b0001, 4'b0001, 1);
    cycle(4'b0011, 4'b0001, 4'b0001, 2);
    @(negedge Clk);
    #1;
    Reset = 1'b1;
    #1;
    check_all_zero("midreset");
    @(posedge Clk);
    #3;
    Reset = 1'b0;
    cycle(4'b0011, 4'b0001, 4'b0001, 0);
    cycle(4'b0011, 4'b0001, 4'b0001, 1);
    cycle(4'b0000, 4'b0000, 4'b0000, -1);
    cycle(4'b0000, 4'b0000, 4'b0000, -1);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
